scr1_dmem_tcm_resp: RTL
=======================

// Module: scr1_dmem_tcm_resp
// PURPOSE
//  Responder (target) end of the DMEM request/ack/response interface: a data tightly-coupled memory.
//  Accepts one LSU-side request at a time, checks the address, performs byte/hword/word read-modify-write
//  on an internal word array, and returns an LSB-aligned load word with RDY_OK/RDY_ER.
//  Sits behind the DMEM router in place of external memory; programmable wait states model slow targets.
// PARAMETERS
//  BASE_ADDR    32'h0001_0000  byte address of word 0; must be word-aligned
//  DEPTH_WORDS  1024           number of 32-bit words in the array; must be a power of 2
//  WAIT_CYCLES  0              extra cycles between accept and response, 0..15
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   synchronous active-high reset
//  dmem_req_i       in   1   request valid
//  dmem_cmd_i       in   1   type_scr1_mem_cmd_e: SCR1_MEM_CMD_RD / SCR1_MEM_CMD_WR
//  dmem_width_i     in   2   type_scr1_mem_width_e: BYTE / HWORD / WORD / ERROR
//  dmem_addr_i      in   32  byte address
//  dmem_wdata_i     in   32  store data, LSB-aligned (byte in [7:0], hword in [15:0])
//  dmem_req_ack_o   out  1   request accepted this cycle when high together with dmem_req_i
//  dmem_rdata_o     out  32  load data, valid only while dmem_resp_o != NOTRDY
//  dmem_resp_o      out  2   type_scr1_mem_resp_e: NOTRDY / RDY_OK / RDY_ER
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, dmem_resp_o = NOTRDY, dmem_rdata_o = 0, dmem_req_ack_o = 1.
//   Array contents are not reset. Reset in any state aborts the transaction; a pending write is never committed.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: dmem_req_ack_o = 1; this is the only state with ack high.
//    Accept on dmem_req_i & ack: latch cmd, width, addr, wdata and the error flag.
//    Next state is WAIT (counter <= WAIT_CYCLES-1) if WAIT_CYCLES>0, else RESP.
//   WAIT: ack = 0. Counter decrements each cycle; on the counter==0 cycle, next state is RESP.
//   RESP: exactly one cycle. dmem_resp_o = RDY_ER if the error flag is set, else RDY_OK; next state is IDLE.
//  Latency: accept at cycle N -> response at cycle N+1+WAIT_CYCLES. Next accept is possible at N+2+WAIT_CYCLES.
//   Requests in WAIT/RESP are ignored; the requester holds them until acked.
//  Error flag, set when any of the following holds:
//   - address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
//   - width == ERROR
//   - HWORD with addr[0] = 1
//   - WORD with addr[1:0] != 0
//  Array access: index = (addr - BASE_ADDR) >> 2; lane = addr[1:0].
//   The access happens on the clock edge that enters RESP.
//  Write (no error): only the addressed lanes are updated.
//   - BYTE:  byte[lane] <= wdata[7:0]
//   - HWORD: bytes[lane+1:lane] <= wdata[15:0]
//   - WORD:  full word
//   On error, no write occurs.
//  Read (no error), rdata register loaded with zero extension (the requester sign-extends):
//   - BYTE:  {24'b0, word[8*lane +: 8]}
//   - HWORD: {16'b0, word[16*lane[1] +: 16]}
//   - WORD:  word
//  Writes return RDY_OK with rdata = 0. Any error response returns rdata = 0.
//  dmem_rdata_o is 0 in every cycle except RESP.
//  Read-after-write to the same word in back-to-back transactions returns the newly written data.
// TESTING
//  1 WAIT_CYCLES=0: WR WORD 0x1_0000 data 0xDEADBEEF, then RD WORD 0x1_0000 -> ack in accept cycle, RDY_OK next cycle, rdata 0xDEADBEEF.
//  2 After 1: WR BYTE 0x1_0002 data 0x55; RD WORD -> 0xDE55BEEF; RD BYTE 0x1_0003 -> 0x000000DE; RD HWORD 0x1_0002 -> 0x0000DE55.
//  3 RD WORD 0x1_0001 / WR HWORD 0x1_0003 / RD WORD 0x0000_FFFC / RD WORD 0x1_1000 (DEPTH 1024) -> each RDY_ER, rdata 0, array unchanged.
//  4 WAIT_CYCLES=3: hold req continuously -> ack high 1 cycle, ack low 4 cycles, RESP at N+4, next ack at N+5.
//  5 Accept WR WORD 0x1_0010 data 0x12345678, assert rst in WAIT -> resp stays NOTRDY, state IDLE, later read shows old contents.
//  6 Width ERROR (2'b11) at a valid address -> RDY_ER; width WORD at 0x1_0FFC (last word) -> RDY_OK.

Source files
------------

// File: rtl/scr1_dmem_tcm_resp.sv
// Data TCM target for the DMEM request/ack/response interface.
// It accepts one request at a time, applies optional wait states, then returns one response cycle.
module scr1_dmem_tcm_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req_i,
  input  logic        dmem_cmd_i,
  input  logic [1:0]  dmem_width_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_req_ack_o,
  output logic [31:0] dmem_rdata_o,
  output logic [1:0]  dmem_resp_o
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic       CMD_WR   = 1'b1;
  localparam logic [1:0] W_BYTE   = 2'd0;
  localparam logic [1:0] W_HWORD  = 2'd1;
  localparam logic [1:0] W_WORD   = 2'd2;
  localparam logic [1:0] W_ERR    = 2'd3;
  localparam logic [1:0] R_NOTRDY = 2'd0;
  localparam logic [1:0] R_OK     = 2'd1;
  localparam logic [1:0] R_ER     = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q;
  logic               cmd_q;
  logic [1:0]         width_q;
  logic [IDX_W+1:0]   off_q;
  logic [31:0]        wdata_q;
  logic               err_q;
  logic               ack_q;
  logic [1:0]         resp_q;
  logic [31:0]        rdata_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        off_in;
  logic               err_in;
  logic               accept;
  logic               enter_resp;
  logic               acc_cmd;
  logic [1:0]         acc_width;
  logic [IDX_W+1:0]   acc_off;
  logic [31:0]        acc_wdata;
  logic               acc_err;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         lane;
  logic [31:0]        rd_word;
  logic [31:0]        rd_val;
  logic [3:0]         be;
  logic [31:0]        wd;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign off_in = dmem_addr_i - BASE_ADDR;
  assign err_in = ((off_in >> 2) >= 32'(DEPTH_WORDS))
               || (dmem_width_i == W_ERR)
               || ((dmem_width_i == W_HWORD) && dmem_addr_i[0])
               || ((dmem_width_i == W_WORD) && (dmem_addr_i[1:0] != 2'b00));

  assign accept = (state_q == ST_IDLE) && dmem_req_i;

  // With no wait states the array is accessed on the accept edge, so use live inputs.
  assign acc_cmd   = accept ? dmem_cmd_i           : cmd_q;
  assign acc_width = accept ? dmem_width_i         : width_q;
  assign acc_off   = accept ? off_in[IDX_W+1:0]    : off_q;
  assign acc_wdata = accept ? dmem_wdata_i         : wdata_q;
  assign acc_err   = accept ? err_in               : err_q;

  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));

  assign idx     = acc_off[IDX_W+1:2];
  assign lane    = acc_off[1:0];
  assign rd_word = mem[idx];

  always_comb begin
    rd_val = rd_word;
    be     = 4'b1111;
    wd     = acc_wdata;
    case (acc_width)
      W_BYTE: begin
        rd_val = {24'b0, rd_word[{lane, 3'b000} +: 8]};
        be     = 4'b0001 << lane;
        wd     = {4{acc_wdata[7:0]}};
      end
      W_HWORD: begin
        rd_val = {16'b0, rd_word[{lane[1], 4'b0000} +: 16]};
        be     = 4'b0011 << lane;
        wd     = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dmem_req_i) state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= 1'b0;
      width_q <= W_BYTE;
      off_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      ack_q   <= 1'b1;
      resp_q  <= R_NOTRDY;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q   <= dmem_cmd_i;
        width_q <= dmem_width_i;
        off_q   <= off_in[IDX_W+1:0];
        wdata_q <= dmem_wdata_i;
        err_q   <= err_in;
        cnt_q   <= CNT_INIT;
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      ack_q   <= (state_d == ST_IDLE);
      resp_q  <= (state_d == ST_RESP) ? (acc_err ? R_ER : R_OK) : R_NOTRDY;
      rdata_q <= (enter_resp && !acc_err && (acc_cmd != CMD_WR)) ? rd_val : 32'd0;
    end
  end

  // Array is never reset; reset at the commit edge drops the pending store.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !acc_err && (acc_cmd == CMD_WR)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign dmem_req_ack_o = ack_q;
  assign dmem_resp_o    = resp_q;
  assign dmem_rdata_o   = rdata_q;

endmodule
